// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared types and constants for the ioctl download source
package ioctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_STROBE = 3'd2,
        ST_GAP    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FINISH = 3'd5
    } ioctl_state_t;

    localparam int IOCTL_WORD_BYTES  = 2;
    localparam int IOCTL_DEFAULT_GAP = 2;

    typedef logic [24:0] ioctl_addr_t;

endpackage

// File: rtl/ioctl_source.sv
// rtl/ioctl_source.sv - streams 16-bit source words onto the ioctl download bus
module ioctl_source
    import ioctl_pkg::*;
#(
    parameter int ADDR_WIDTH = $bits(ioctl_addr_t),
    parameter int GAP_CYCLES = IOCTL_DEFAULT_GAP
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            index,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  src_valid,
    input  logic [15:0]           src_data,
    output logic                  src_ready,
    output logic                  ioctl_download,
    output logic [7:0]            ioctl_index,
    output logic                  ioctl_wr,
    output logic [ADDR_WIDTH-1:0] ioctl_addr,
    output logic [15:0]           ioctl_dout,
    input  logic                  ioctl_wait,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(IOCTL_WORD_BYTES);
    localparam logic [3:0]            GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    ioctl_state_t          state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] words_left;
    logic [3:0]            gap_cnt;
    logic                  fetch_ok;

    // The source handshake happens in the cycle before the write strobe.
    assign fetch_ok  = (state == ST_FETCH) && (words_left != '0) &&
                       src_valid && !ioctl_wait && !abort;
    assign src_ready = fetch_ok;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            next_addr      <= '0;
            words_left     <= '0;
            gap_cnt        <= '0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            done           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ioctl_index    <= index;
                        words_left     <= {1'b0, len[ADDR_WIDTH-1:1]} + ADDR_WIDTH'(len[0]);
                        next_addr      <= '0;
                        ioctl_download <= 1'b1;
                        state          <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (words_left == '0 || abort) begin
                        state <= ST_DRAIN;
                    end else if (fetch_ok) begin
                        ioctl_dout <= src_data;
                        ioctl_addr <= next_addr;
                        ioctl_wr   <= 1'b1;
                        state      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    ioctl_wr   <= 1'b0;
                    next_addr  <= next_addr + ADDR_STEP;
                    words_left <= words_left - ADDR_WIDTH'(1);
                    // The last word skips the gap so download falls two cycles after it.
                    if (abort || words_left == ADDR_WIDTH'(1)) begin
                        state <= ST_DRAIN;
                    end else if (GAP_CYCLES == 0) begin
                        state <= ST_FETCH;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state <= ST_DRAIN;
                    end else if (gap_cnt == 4'd0) begin
                        state <= ST_FETCH;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!ioctl_wait) begin
                        ioctl_download <= 1'b0;
                        done           <= 1'b1;
                        state          <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_source.sv
// tb/tb_ioctl_source.sv - directed self-checking bench for ioctl_source
module tb_ioctl_source;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  index;
    logic [24:0] len;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        busy;
    logic        done;

    logic        src_avail;
    logic        src_hold;
    logic [15:0] src_q[$];
    bit          hs;

    int          checks;
    int          failures;
    int          cyc;
    int          wr_count;
    int          done_count;
    int          done_cyc;
    int          dl_cycles;
    logic [24:0] wr_addr[$];
    logic [15:0] wr_dout[$];
    int          wr_cyc[$];

    always #5 clock = ~clock;

    assign src_valid = src_avail & ~src_hold;

    ioctl_source dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .index          (index),
        .len            (len),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
        .done           (done)
    );

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        hs = src_valid && src_ready;
        if (ioctl_download) dl_cycles++;
        if (ioctl_wr) begin
            wr_addr.push_back(ioctl_addr);
            wr_dout.push_back(ioctl_dout);
            wr_cyc.push_back(cyc);
            wr_count++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    // Source model: pops a word after each handshake seen at the previous negedge.
    always begin
        @(posedge clock);
        #1;
        if (hs) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            hs = 1'b0;
        end
        src_avail = (src_q.size() != 0);
        src_data  = src_avail ? src_q[0] : 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_dout.delete();
        wr_cyc.delete();
        wr_count   = 0;
        done_count = 0;
        done_cyc   = 0;
        dl_cycles  = 0;
    endtask

    task automatic do_start(input logic [7:0] idx, input logic [24:0] l);
        @(posedge clock); #1;
        index = idx;
        len   = l;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done_count == 0 && n < max_cycles) begin
            @(posedge clock);
            n++;
        end
        check("done_seen", 32'(done_count != 0), 32'd1);
    endtask

    task automatic wait_wr(input int target, input int max_cycles);
        int n;
        n = 0;
        while (wr_count < target && n < max_cycles) begin
            @(posedge clock);
            n++;
        end
        check("wr_reached", 32'(wr_count >= target), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_download"}, 32'(ioctl_download), 32'd0);
        check({tag, "_wr"},       32'(ioctl_wr),       32'd0);
        check({tag, "_busy"},     32'(busy),           32'd0);
        check({tag, "_done"},     32'(done),           32'd0);
        check({tag, "_ready"},    32'(src_ready),      32'd0);
    endtask

    task automatic load_words(input logic [15:0] base, input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(base + 16'(i));
        @(posedge clock); #1;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; index = 8'h00; len = '0;
        ioctl_wait = 1'b0; src_hold = 1'b0; src_avail = 1'b0; src_data = 16'h0;
        clear_log();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("rst");
        check("rst_addr",  32'(ioctl_addr),  32'd0);
        check("rst_dout",  32'(ioctl_dout),  32'd0);
        check("rst_index", 32'(ioctl_index), 32'd0);

        // len=8: four words, spaced GAP+2=4 cycles, done 2 cycles after last wr
        src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        @(posedge clock); #1;
        clear_log();
        do_start(8'h00, 25'd8);
        wait_done(100);
        check("t1_wr_count", 32'(wr_count), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check("t1_addr", 32'(wr_addr[i]), 32'(2 * i));
            check("t1_dout", 32'(wr_dout[i]), 32'(16'h1111 * (i + 1)));
            if (i > 0) check("t1_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
        end
        if (wr_cyc.size() == 4) check("t1_done_lat", 32'(done_cyc - wr_cyc[3]), 32'd2);
        @(negedge clock);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_dl_after",   32'(ioctl_download), 32'd0);
        check("t1_index",      32'(ioctl_index), 32'h00);

        // len=5 rounds up to three words; a start while busy is ignored
        load_words(16'hA001, 3);
        clear_log();
        do_start(8'h05, 25'd5);
        @(posedge clock); #1;
        index = 8'hEE; len = 25'd100; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(100);
        check("t2_wr_count", 32'(wr_count), 32'd3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check("t2_addr", 32'(wr_addr[i]), 32'(2 * i));
            check("t2_dout", 32'(wr_dout[i]), 32'(16'hA001 + i));
        end
        check("t2_index", 32'(ioctl_index), 32'h05);
        repeat (5) @(posedge clock);
        check("t2_no_restart", 32'(wr_count), 32'd3);

        // len=4 with ioctl_wait high for 10 cycles starting on the first wr
        load_words(16'hB101, 2);
        clear_log();
        do_start(8'h02, 25'd4);
        @(posedge clock); #1;
        ioctl_wait = 1'b1;
        repeat (10) @(posedge clock);
        #1 ioctl_wait = 1'b0;
        wait_done(100);
        check("t3_wr_count", 32'(wr_count), 32'd2);
        if (wr_cyc.size() == 2) begin
            check("t3_wait_delay", 32'(wr_cyc[1] - wr_cyc[0]), 32'd11);
            check("t3_dout2", 32'(wr_dout[1]), 32'hB102);
            check("t3_addr2", 32'(wr_addr[1]), 32'd2);
        end

        // source starved for 7 cycles between words
        load_words(16'hB001, 2);
        clear_log();
        do_start(8'h03, 25'd4);
        @(posedge clock); #1;
        src_hold = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("t4_dl_held", 32'(ioctl_download), 32'd1);
            check("t4_no_wr",   32'(ioctl_wr),       32'd0);
            check("t4_addr",    32'(ioctl_addr),     32'd0);
            check("t4_dout",    32'(ioctl_dout),     32'hB001);
        end
        @(posedge clock); #1;
        src_hold = 1'b0;
        wait_done(100);
        check("t4_wr_count", 32'(wr_count), 32'd2);
        if (wr_cyc.size() == 2) check("t4_starve_delay", 32'(wr_cyc[1] - wr_cyc[0]), 32'd8);

        // abort two cycles after the third wr of a 16-byte transfer
        load_words(16'hC001, 8);
        clear_log();
        do_start(8'h04, 25'd16);
        wait_wr(3, 100);
        #1;
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        wait_done(100);
        check("t5_wr_count", 32'(wr_count), 32'd3);
        if (wr_cyc.size() >= 3) check("t5_done_lat", 32'(done_cyc - wr_cyc[2]), 32'd4);
        @(negedge clock);
        check("t5_busy_after", 32'(busy), 32'd0);
        repeat (5) @(posedge clock);
        check("t5_no_more_wr", 32'(wr_count), 32'd3);

        // zero length: download high two cycles, no wr
        load_words(16'hE000, 0);
        clear_log();
        do_start(8'h06, 25'd0);
        wait_done(20);
        @(negedge clock);
        check("t6_wr_count", 32'(wr_count), 32'd0);
        check("t6_dl_cycles", 32'(dl_cycles), 32'd2);

        // reset in the gap after word 2, then a fresh one-word transfer
        load_words(16'hF001, 4);
        clear_log();
        do_start(8'h7A, 25'd8);
        wait_wr(2, 100);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("t7_rst");
        check("t7_rst_addr",  32'(ioctl_addr),  32'd0);
        check("t7_rst_dout",  32'(ioctl_dout),  32'd0);
        check("t7_rst_index", 32'(ioctl_index), 32'd0);
        repeat (10) @(posedge clock);
        check("t7_no_done", 32'(done_count), 32'd0);
        load_words(16'hD00D, 1);
        clear_log();
        do_start(8'h01, 25'd2);
        wait_done(100);
        check("t7_wr_count", 32'(wr_count), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t7_addr", 32'(wr_addr[0]), 32'd0);
            check("t7_dout", 32'(wr_dout[0]), 32'hD00D);
        end
        check("t7_index", 32'(ioctl_index), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
